// File: rtl/frame_lock_detector.sv
// frame_lock_detector: qualifies the camera sync stream (vsync/href) and
// raises `locked` after LOCK_FRAMES consecutive well-formed frames.
// Optional: define LOCK_ERR_CNT_EN to add the saturating err_cnt output.
//
// Two register stages: stage A detects edges, measures lines and snapshots
// the closing frame's verdict on vs_rise; stage B runs the lock FSM and
// drives the registered outputs. A frame boundary therefore shows up on the
// outputs two pclk edges after vsync_in is first sampled high.
module frame_lock_detector #(
    parameter int EXP_LINES       = 480,
    parameter int EXP_LINE_CYCLES = 1280,
    parameter int LOCK_FRAMES     = 3,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        href_in,
    output logic        locked,
    output logic        frame_good,
    output logic        frame_bad,
    output logic [9:0]  last_lines,
    output logic [10:0] last_line_len
`ifdef LOCK_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [9:0]  EXP_NL  = 10'(EXP_LINES);
    localparam logic [10:0] EXP_LEN = 11'(EXP_LINE_CYCLES);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [19:0] TO_VAL  = 20'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    // ---------------- stage A: edge detect and line/frame measurement
    logic        vs_q, hr_q;
    logic [10:0] len_cnt_q, len_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic [10:0] last_line_len_q, last_line_len_d;
    logic [19:0] to_cnt_q, to_cnt_d;
    logic        close_q, close_good_q, close_good_d;
    logic [9:0]  close_lines_q, close_lines_d;
    logic        timeout_q, timeout_d;
    logic        vs_rise, hr_rise, hr_fall;
    logic [9:0]  lines_inc;
    logic        err_eff;

    assign vs_rise = vsync_in & ~vs_q;
    assign hr_rise = href_in & ~hr_q;
    assign hr_fall = ~href_in & hr_q;

    // Measure lines; a line ending on the boundary cycle belongs to the closing frame.
    always_comb begin
        len_cnt_d       = len_cnt_q;
        last_line_len_d = last_line_len_q;
        to_cnt_d        = to_cnt_q;
        close_good_d    = 1'b0;
        close_lines_d   = close_lines_q;
        timeout_d       = 1'b0;
        lines_inc       = line_cnt_q;
        err_eff         = frame_err_q;

        if (hr_rise)
            len_cnt_d = 11'd1;
        else if (href_in && len_cnt_q != 11'h7FF)
            len_cnt_d = len_cnt_q + 11'd1;

        if (hr_fall) begin
            last_line_len_d = len_cnt_q;
            if (line_cnt_q != 10'h3FF)
                lines_inc = line_cnt_q + 10'd1;
            if (len_cnt_q != EXP_LEN)
                err_eff = 1'b1;
        end
        if (hr_rise && vsync_in)
            err_eff = 1'b1;

        line_cnt_d  = lines_inc;
        frame_err_d = err_eff;

        if (vs_rise) begin
            close_lines_d = lines_inc;
            close_good_d  = (lines_inc == EXP_NL) && !err_eff;
            line_cnt_d    = 10'd0;
            frame_err_d   = 1'b0;
            to_cnt_d      = 20'd0;
        end else begin
            if (to_cnt_q != 20'hFFFFF)
                to_cnt_d = to_cnt_q + 20'd1;
            // Exact match gives a single event even while the counter saturates.
            timeout_d = (to_cnt_d == TO_VAL);
        end
    end

    // Stage A registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vs_q            <= 1'b0;
            hr_q            <= 1'b0;
            len_cnt_q       <= '0;
            line_cnt_q      <= '0;
            frame_err_q     <= 1'b0;
            last_line_len_q <= '0;
            to_cnt_q        <= '0;
            close_q         <= 1'b0;
            close_good_q    <= 1'b0;
            close_lines_q   <= '0;
            timeout_q       <= 1'b0;
        end else begin
            vs_q            <= vsync_in;
            hr_q            <= href_in;
            len_cnt_q       <= len_cnt_d;
            line_cnt_q      <= line_cnt_d;
            frame_err_q     <= frame_err_d;
            last_line_len_q <= last_line_len_d;
            to_cnt_q        <= to_cnt_d;
            close_q         <= vs_rise;
            close_good_q    <= close_good_d;
            close_lines_q   <= close_lines_d;
            timeout_q       <= timeout_d;
        end
    end

    // ---------------- stage B: lock FSM and output registers
    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d, good_cnt_inc;
    logic        locked_q, locked_d;
    logic        frame_good_q, frame_good_d;
    logic        frame_bad_q, frame_bad_d;
    logic [9:0]  last_lines_q, last_lines_d;
    logic        err_evt;

    assign good_cnt_inc = good_cnt_q + 4'd1;

    // Next state: sync loss wins; otherwise evaluate each frame close.
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        frame_good_d = 1'b0;
        frame_bad_d  = 1'b0;
        last_lines_d = last_lines_q;
        err_evt      = 1'b0;

        if (timeout_q && state_q != IDLE) begin
            state_d    = IDLE;
            good_cnt_d = 4'd0;
            locked_d   = 1'b0;
            err_evt    = 1'b1;
        end else if (close_q) begin
            last_lines_d = close_lines_q;
            case (state_q)
                IDLE: state_d = ACQUIRE;
                ACQUIRE: begin
                    if (close_good_q) begin
                        frame_good_d = 1'b1;
                        good_cnt_d   = good_cnt_inc;
                        if (good_cnt_inc >= LOCK_N) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        frame_bad_d = 1'b1;
                        good_cnt_d  = 4'd0;
                        err_evt     = 1'b1;
                    end
                end
                LOCKED: begin
                    if (close_good_q) begin
                        frame_good_d = 1'b1;
                    end else begin
                        frame_bad_d = 1'b1;
                        good_cnt_d  = 4'd0;
                        locked_d    = 1'b0;
                        state_d     = ACQUIRE;
                        err_evt     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage B registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q      <= IDLE;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            last_lines_q <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            frame_good_q <= frame_good_d;
            frame_bad_q  <= frame_bad_d;
            last_lines_q <= last_lines_d;
        end
    end

`ifdef LOCK_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count bad frames and sync losses, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_evt && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge pclk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

    assign locked        = locked_q;
    assign frame_good    = frame_good_q;
    assign frame_bad     = frame_bad_q;
    assign last_lines    = last_lines_q;
    assign last_line_len = last_line_len_q;

endmodule

// File: tb/tb_frame_lock_detector.sv
// Directed, table-driven bench for frame_lock_detector (small frame geometry).
module tb_frame_lock_detector;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        href_in = 1'b0;
    logic        locked, frame_good, frame_bad;
    logic [9:0]  last_lines;
    logic [10:0] last_line_len;
`ifdef LOCK_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;

    frame_lock_detector #(
        .EXP_LINES(4), .EXP_LINE_CYCLES(8), .LOCK_FRAMES(3), .TIMEOUT_CYCLES(200)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .href_in(href_in),
        .locked(locked), .frame_good(frame_good), .frame_bad(frame_bad),
        .last_lines(last_lines), .last_line_len(last_line_len)
`ifdef LOCK_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1);
    end

    typedef struct {
        int nlines;
        int len_last;
        int g;
        int b;
        int l;
        int lines;
        int llen;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one pclk edge; return 1 time unit after the edge.
    task automatic cyc(input logic vs, input logic hr);
        vsync_in = vs;
        href_in  = hr;
        @(posedge pclk);
        #1;
    endtask

    task automatic line(input int len);
        for (int i = 0; i < len; i++) cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic frame(input int n, input int len_last);
        for (int i = 0; i < n; i++) line((i == n - 1) ? len_last : 8);
    endtask

    // vsync pulse; outputs are checked on the second edge, then pulses must clear.
    task automatic close_chk(input string tag, input int g, input int b, input int l,
                             input int lines, input int llen);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk({tag, ".frame_good"}, int'(frame_good), g);
        chk({tag, ".frame_bad"}, int'(frame_bad), b);
        chk({tag, ".locked"}, int'(locked), l);
        if (lines >= 0) chk({tag, ".last_lines"}, int'(last_lines), lines);
        chk({tag, ".last_line_len"}, int'(last_line_len), llen);
        cyc(1'b0, 1'b0);
        chk({tag, ".good_1cyc"}, int'(frame_good), 0);
        chk({tag, ".bad_1cyc"}, int'(frame_bad), 0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".locked"}, int'(locked), 0);
        chk({tag, ".frame_good"}, int'(frame_good), 0);
        chk({tag, ".frame_bad"}, int'(frame_bad), 0);
        chk({tag, ".last_lines"}, int'(last_lines), 0);
        chk({tag, ".last_line_len"}, int'(last_line_len), 0);
`ifdef LOCK_ERR_CNT_EN
        chk({tag, ".err_cnt"}, int'(err_cnt), 0);
`endif
    endtask

    initial begin
        int pulses;
        // nlines, len_last, good, bad, locked, last_lines, last_line_len
        vecs[0]  = '{0, 8, 0, 0, 0, 0, 0};   // first boundary: no pulse
        vecs[1]  = '{4, 8, 1, 0, 0, 4, 8};
        vecs[2]  = '{4, 8, 1, 0, 0, 4, 8};
        vecs[3]  = '{4, 8, 1, 0, 1, 4, 8};   // third good -> lock
        vecs[4]  = '{4, 8, 1, 0, 1, 4, 8};
        vecs[5]  = '{4, 7, 0, 1, 0, 4, 7};   // short line drops lock
        vecs[6]  = '{4, 8, 1, 0, 0, 4, 8};
        vecs[7]  = '{4, 8, 1, 0, 0, 4, 8};
        vecs[8]  = '{4, 8, 1, 0, 1, 4, 8};
        vecs[9]  = '{5, 8, 0, 1, 0, 5, 8};   // wrong line count
        vecs[10] = '{4, 8, 1, 0, 0, 4, 8};
        vecs[11] = '{4, 7, 0, 1, 0, 4, 7};   // bad in ACQUIRE restarts count
        vecs[12] = '{4, 8, 1, 0, 0, 4, 8};
        vecs[13] = '{4, 8, 1, 0, 0, 4, 8};
        vecs[14] = '{4, 8, 1, 0, 1, 4, 8};

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
        chk_reset("reset");
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            frame(vecs[i].nlines, vecs[i].len_last);
            close_chk($sformatf("vec%0d", i), vecs[i].g, vecs[i].b, vecs[i].l,
                      vecs[i].lines, vecs[i].llen);
            if (vecs[i].b != 0) exp_err++;
        end

        // Last line's href falls on the very cycle vsync rises.
        frame(3, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        chk("simul.frame_good", int'(frame_good), 1);
        chk("simul.frame_bad", int'(frame_bad), 0);
        chk("simul.locked", int'(locked), 1);
        chk("simul.last_lines", int'(last_lines), 4);
        cyc(1'b0, 1'b0);
        chk("simul.good_1cyc", int'(frame_good), 0);
        cyc(1'b0, 1'b0);

        // Sync loss: no vsync for longer than the timeout.
        for (int i = 0; i < 150; i++) cyc(1'b0, 1'b0);
        chk("timeout.locked_before", int'(locked), 1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1'b0, 1'b0);
            if (frame_good || frame_bad) pulses++;
        end
        chk("timeout.no_pulses", pulses, 0);
        chk("timeout.locked_after", int'(locked), 0);
        exp_err++;
`ifdef LOCK_ERR_CNT_EN
        chk("timeout.err_cnt", int'(err_cnt), exp_err);
`endif
        close_chk("restart", 0, 0, 0, -1, 8);
        frame(4, 8);
        close_chk("relock1", 1, 0, 0, 4, 8);
        frame(4, 8);
        close_chk("relock2", 1, 0, 0, 4, 8);
        frame(4, 8);
        close_chk("relock3", 1, 0, 1, 4, 8);

        // Reset in the middle of a locked frame.
        frame(2, 8);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        chk_reset("midrst");
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        // href in IDLE only updates last_line_len.
        line(6);
        chk("idle.last_line_len", int'(last_line_len), 6);
        chk("idle.locked", int'(locked), 0);
        close_chk("idle.first_vs", 0, 0, 0, -1, 6);
        frame(4, 8);
        close_chk("after_rst", 1, 0, 0, 4, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
